butterfly_p2s_serializer: RTL and testbench

- Parametrised parallel-to-serial output stage for the butterfly processor.
- Accepts one word of PAR = 2*BU_PARALLELISM elements per butterfly-engine lane, across BE_PARALLELISM lanes.
- Emits the elements one per cycle per lane on a serial port, or forwards whole words to a parallel port in bypass mode.
- Adds over the previous generation: a per-channel valid mask, frame-length counting with a last flag, per-word mode tagging and two-entry buffering with backpressure.

---
 rtl/butterfly_pkg.sv | 41 ++++
 rtl/butterfly_p2s_serializer_if.sv | 33 +++
 rtl/p2s_word_fifo.sv | 66 ++++++
 rtl/butterfly_p2s_serializer.sv | 112 +++++++++++
 tb/tb_butterfly_p2s_serializer.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/butterfly_pkg.sv
// Shared types and constants for the butterfly parallel-to-serial output stage.
//   PAR          elements per lane per word (2 * BU_PARALLELISM)
//   WORD_W       width of one full parallel word across all lanes
//   SER_W        width of one serial beat (one element per lane)
//   p2s_entry_t  buffered word: data, per-channel mask, per-word mode
package butterfly_pkg;

    localparam int DATA_WIDTH     = 16;
    localparam int BE_PARALLELISM = 32;
    localparam int BU_PARALLELISM = 4;
    localparam int PAR            = 2 * BU_PARALLELISM;
    localparam int AXI_CHNL       = 8;
    localparam int LEN_WIDTH      = 16;

    localparam int LANES_PER_CHNL = BE_PARALLELISM / AXI_CHNL;
    localparam int WORD_W         = PAR * DATA_WIDTH * BE_PARALLELISM;
    localparam int SER_W          = DATA_WIDTH * BE_PARALLELISM;
    localparam int IDX_W          = $clog2(PAR);

    typedef enum logic {
        P2S_MODE_SERIAL = 1'b0,
        P2S_MODE_BYPASS = 1'b1
    } p2s_mode_e;

    typedef enum logic {
        ST_WORD_START = 1'b0,
        ST_WORD_MID   = 1'b1
    } ser_state_e;

    typedef struct packed {
        logic [WORD_W-1:0]   data;
        logic [AXI_CHNL-1:0] mask;
        p2s_mode_e           mode;
    } p2s_entry_t;

    // Channel that owns a given lane (channels cover contiguous lane groups).
    function automatic int lane_chnl(input int lane);
        return lane / LANES_PER_CHNL;
    endfunction

endpackage

// File: rtl/butterfly_p2s_serializer_if.sv
// Bus bundle of the p2s serializer: upstream word input, frame length and
// mode select, serial downstream port and parallel (bypass) downstream port.
//   master : the side that produces words and sinks the outputs
//   slave  : the serializer
interface butterfly_p2s_serializer_if;
    import butterfly_pkg::*;

    logic [LEN_WIDTH-1:0] length;
    logic                 is_bypass_p2s;
    logic [AXI_CHNL-1:0]  up_vld;
    logic [WORD_W-1:0]    up_dat;
    logic                 up_rdy;
    logic [AXI_CHNL-1:0]  dn_serial_vld;
    logic [SER_W-1:0]     dn_serial_dat;
    logic                 dn_serial_last;
    logic                 dn_serial_rdy;
    logic [AXI_CHNL-1:0]  dn_parallel_vld;
    logic [WORD_W-1:0]    dn_parallel_dat;
    logic                 dn_parallel_rdy;

    modport master (
        output length, is_bypass_p2s, up_vld, up_dat, dn_serial_rdy, dn_parallel_rdy,
        input  up_rdy, dn_serial_vld, dn_serial_dat, dn_serial_last,
               dn_parallel_vld, dn_parallel_dat
    );

    modport slave (
        input  length, is_bypass_p2s, up_vld, up_dat, dn_serial_rdy, dn_parallel_rdy,
        output up_rdy, dn_serial_vld, dn_serial_dat, dn_serial_last,
               dn_parallel_vld, dn_parallel_dat
    );

endinterface

// File: rtl/p2s_word_fifo.sv
// Two-entry word buffer for the p2s serializer.
//   push_i     write wr_entry_i (taken only while rdy_o is high)
//   pop_i      drop the head entry (ignored when empty)
//   head_o     oldest entry, valid while empty_o is low
//   rdy_o      registered: next occupancy < 2; low during reset
//   full_o / empty_o occupancy flags
module p2s_word_fifo
    import butterfly_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic       pop_i,
    input  p2s_entry_t wr_entry_i,
    output p2s_entry_t head_o,
    output logic       rdy_o,
    output logic       full_o,
    output logic       empty_o
);

    p2s_entry_t mem_q [2];
    logic [1:0] count_q, count_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic       rdy_q, rdy_d;
    logic       push_ok, pop_ok;

    // Push is gated by the registered ready, so a full buffer never takes a
    // word even if the head pops in the same cycle.
    assign push_ok = push_i && rdy_q;
    assign pop_ok  = pop_i && (count_q != 2'd0);

    always_comb begin
        count_d  = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        wr_ptr_d = push_ok ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop_ok  ? ~rd_ptr_q : rd_ptr_q;
        rdy_d    = (count_d < 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rdy_q    <= rdy_d;
        end
    end

    // Storage needs no reset: contents are only observed while count_q > 0.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_entry_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign rdy_o   = rdy_q;
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/butterfly_p2s_serializer.sv
// Parallel-to-serial output stage of the butterfly processor.
// Buffers up to two words; a serial-mode head word is emitted one element
// per lane per cycle (element 0 first), a bypass-mode head word goes out
// whole on the parallel port. A frame counter flags the last serial element.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of butterfly_p2s_serializer_if
//
// state         | meaning
// ST_WORD_START | next serial element is element 0 of the head word
// ST_WORD_MID   | a serial word is partly emitted; the head is locked to it
module butterfly_p2s_serializer
    import butterfly_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    butterfly_p2s_serializer_if.slave bus
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAR - 1);

    p2s_entry_t           wr_entry, head;
    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty, up_rdy;
    ser_state_e           st_q, st_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d, len_q, len_d, len_cur;
    logic                 ser_active, par_active, ser_xfer, par_xfer, frame_last;
    logic [SER_W-1:0]     ser_dat;

    always_comb begin
        wr_entry.data = bus.up_dat;
        wr_entry.mask = bus.up_vld;
        wr_entry.mode = bus.is_bypass_p2s ? P2S_MODE_BYPASS : P2S_MODE_SERIAL;
    end

    assign fifo_push = (|bus.up_vld) && up_rdy && !fifo_full;

    p2s_word_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (fifo_push),
        .pop_i      (fifo_pop),
        .wr_entry_i (wr_entry),
        .head_o     (head),
        .rdy_o      (up_rdy),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // Stored masks are never zero (accept requires |up_vld), so an active
    // serial head always presents a valid beat.
    assign ser_active = !fifo_empty && (head.mode == P2S_MODE_SERIAL);
    assign par_active = !fifo_empty && (head.mode == P2S_MODE_BYPASS)
                        && (st_q == ST_WORD_START);
    assign ser_xfer   = ser_active && bus.dn_serial_rdy;
    assign par_xfer   = par_active && bus.dn_parallel_rdy;

    // Length is sampled live at frame start and held for the rest of the
    // frame. length == 0 gives len-1 == all ones, i.e. a 2^LEN_WIDTH frame.
    assign len_cur    = (cnt_q == '0) ? bus.length : len_q;
    assign frame_last = (cnt_q == len_cur - LEN_WIDTH'(1));

    always_comb begin
        st_d     = st_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        len_d    = len_cur;
        fifo_pop = par_xfer;
        if (ser_xfer) begin
            cnt_d = frame_last ? '0 : cnt_q + LEN_WIDTH'(1);
            if (idx_q == IDX_LAST) begin
                idx_d    = '0;
                st_d     = ST_WORD_START;
                fifo_pop = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
                st_d  = ST_WORD_MID;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= ST_WORD_START;
            idx_q <= '0;
            cnt_q <= '0;
            len_q <= '0;
        end else begin
            st_q  <= st_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            len_q <= len_d;
        end
    end

    always_comb begin
        ser_dat = '0;
        for (int l = 0; l < BE_PARALLELISM; l++) begin
            if (ser_active && head.mask[lane_chnl(l)]) begin
                ser_dat[l*DATA_WIDTH +: DATA_WIDTH] =
                    head.data[(l*PAR + int'(idx_q))*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.up_rdy          = up_rdy;
    assign bus.dn_serial_vld   = ser_active ? head.mask : '0;
    assign bus.dn_serial_dat   = ser_dat;
    assign bus.dn_serial_last  = ser_active && frame_last;
    assign bus.dn_parallel_vld = par_active ? head.mask : '0;
    assign bus.dn_parallel_dat = par_active ? head.data : '0;

endmodule

// File: tb/tb_butterfly_p2s_serializer.sv
// Self-checking bench for butterfly_p2s_serializer. Expected serial beats and
// parallel words are queued when a word is accepted and compared as the DUT
// transfers them.
module tb_butterfly_p2s_serializer;
    import butterfly_pkg::*;

    typedef struct {
        logic [AXI_CHNL-1:0] vld;
        logic [SER_W-1:0]    dat;
        logic                last;
    } ser_exp_t;

    typedef struct {
        logic [AXI_CHNL-1:0] vld;
        logic [WORD_W-1:0]   dat;
        int                  ser_before;
    } par_exp_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    butterfly_p2s_serializer_if bus ();

    butterfly_p2s_serializer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ser_exp_t sq[$];
    par_exp_t pq[$];
    int n_vec = 0;
    int n_err = 0;
    int sb_cnt = 0;
    int sb_len = 1;
    int ser_pushed = 0;
    int ser_xfers = 0;
    int n_last = 0;
    int cyc = 0;
    int last_ser_cyc = -10;
    bit seen_rdy_low = 1'b0;

    logic                prev_stall = 1'b0;
    logic [AXI_CHNL-1:0] prev_vld;
    logic [SER_W-1:0]    prev_dat;
    logic                prev_last;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] mk_word(input logic [15:0] base);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int l = 0; l < BE_PARALLELISM; l++)
            for (int e = 0; e < PAR; e++)
                w[(l*PAR+e)*DATA_WIDTH +: DATA_WIDTH] = base + 16'(l*PAR + e);
        return w;
    endfunction

    function automatic logic [WORD_W-1:0] fill_word(input logic [15:0] val);
        logic [WORD_W-1:0] w;
        for (int i = 0; i < BE_PARALLELISM*PAR; i++)
            w[i*DATA_WIDTH +: DATA_WIDTH] = val;
        return w;
    endfunction

    task automatic push_exp(input logic [WORD_W-1:0] word, input logic [AXI_CHNL-1:0] mask,
                            input logic mode);
        ser_exp_t s;
        par_exp_t p;
        if (mode) begin
            p.vld = mask;
            p.dat = word;
            p.ser_before = ser_pushed;
            pq.push_back(p);
        end else begin
            for (int e = 0; e < PAR; e++) begin
                s.vld = mask;
                s.dat = '0;
                for (int l = 0; l < BE_PARALLELISM; l++)
                    if (mask[l / LANES_PER_CHNL])
                        s.dat[l*DATA_WIDTH +: DATA_WIDTH] = word[(l*PAR+e)*DATA_WIDTH +: DATA_WIDTH];
                if (sb_cnt == 0)
                    sb_len = (bus.length == '0) ? (1 << LEN_WIDTH) : int'(bus.length);
                s.last = (sb_cnt == sb_len - 1);
                sb_cnt = s.last ? 0 : sb_cnt + 1;
                sq.push_back(s);
            end
            ser_pushed += PAR;
        end
    endtask

    // Called just after a rising edge; returns 1 ns after the accepting edge.
    task automatic send_word(input logic [WORD_W-1:0] word, input logic [AXI_CHNL-1:0] mask,
                             input logic mode);
        bit ok;
        ok = 1'b0;
        bus.up_dat        = word;
        bus.up_vld        = mask;
        bus.is_bypass_p2s = mode;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.up_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_wait", 512'(ok), 512'(1));
        if (ok) push_exp(word, mask, mode);
        @(posedge clk);
        #1;
        bus.up_vld        = '0;
        bus.is_bypass_p2s = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (sq.size() == 0 && pq.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain", 512'(done), 512'(1));
        @(negedge clk);
        chk("drain_idle_ser", 512'(bus.dn_serial_vld), 512'(0));
        chk("drain_idle_par", 512'(bus.dn_parallel_vld), 512'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        sq.delete();
        pq.delete();
        sb_cnt     = 0;
        ser_pushed = ser_xfers;
    endtask

    always @(negedge clk) begin
        ser_exp_t s;
        par_exp_t p;
        cyc++;
        if (rst_n) begin
            chk("port_excl", 512'((|bus.dn_serial_vld) && (|bus.dn_parallel_vld)), 512'(0));
            if (prev_stall) begin
                chk("hold_vld", 512'(bus.dn_serial_vld), 512'(prev_vld));
                chk("hold_dat", 512'(bus.dn_serial_dat), 512'(prev_dat));
                chk("hold_last", 512'(bus.dn_serial_last), 512'(prev_last));
            end
            if ((|bus.dn_serial_vld) && bus.dn_serial_rdy) begin
                if (sq.size() == 0) begin
                    chk("ser_unexpected", 512'(bus.dn_serial_vld), 512'(0));
                end else begin
                    s = sq.pop_front();
                    chk("ser_vld", 512'(bus.dn_serial_vld), 512'(s.vld));
                    chk("ser_dat", 512'(bus.dn_serial_dat), 512'(s.dat));
                    chk("ser_last", 512'(bus.dn_serial_last), 512'(s.last));
                end
                ser_xfers++;
                if (bus.dn_serial_last) n_last++;
                last_ser_cyc = cyc;
            end
            if ((|bus.dn_parallel_vld) && bus.dn_parallel_rdy) begin
                if (pq.size() == 0) begin
                    chk("par_unexpected", 512'(bus.dn_parallel_vld), 512'(0));
                end else begin
                    p = pq.pop_front();
                    chk("par_vld", 512'(bus.dn_parallel_vld), 512'(p.vld));
                    for (int k = 0; k < WORD_W/512; k++)
                        chk($sformatf("par_dat%0d", k), bus.dn_parallel_dat[k*512 +: 512],
                            p.dat[k*512 +: 512]);
                    chk("par_order", 512'(ser_xfers), 512'(p.ser_before));
                    chk("par_gap", 512'(cyc - last_ser_cyc), 512'(1));
                end
            end
            if (!bus.up_rdy) seen_rdy_low = 1'b1;
            prev_stall = (|bus.dn_serial_vld) && !bus.dn_serial_rdy;
            prev_vld   = bus.dn_serial_vld;
            prev_dat   = bus.dn_serial_dat;
            prev_last  = bus.dn_serial_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit reached;
        int base;
        int lasts0;

        bus.length          = 16'd128;
        bus.is_bypass_p2s   = 1'b0;
        bus.up_vld          = '0;
        bus.up_dat          = '0;
        bus.dn_serial_rdy   = 1'b1;
        bus.dn_parallel_rdy = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_up_rdy", 512'(bus.up_rdy), 512'(0));
        chk("rst_ser_vld", 512'(bus.dn_serial_vld), 512'(0));
        chk("rst_par_vld", 512'(bus.dn_parallel_vld), 512'(0));
        chk("rst_last", 512'(bus.dn_serial_last), 512'(0));
        chk("rst_ser_dat", 512'(bus.dn_serial_dat), 512'(0));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_up_rdy_held", 512'(bus.up_rdy), 512'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rdy_after_rst", 512'(bus.up_rdy), 512'(1));

        // First word: latency and eight contiguous beats
        send_word(mk_word(16'h1000), 8'hFF, 1'b0);
        for (int i = 0; i < PAR; i++) begin
            @(negedge clk);
            chk("t1_vld", 512'(bus.dn_serial_vld), 512'(8'hFF));
        end
        @(negedge clk);
        chk("t1_idle", 512'(bus.dn_serial_vld), 512'(0));
        @(posedge clk);
        #1;
        wait_drain();

        // Partial channel mask
        send_word(mk_word(16'h2000), 8'h0F, 1'b0);
        @(negedge clk);
        chk("mask_vld", 512'(bus.dn_serial_vld), 512'(8'h0F));
        chk("mask_hi_zero", 512'(bus.dn_serial_dat[SER_W-1:SER_W/2]), 512'(0));
        @(posedge clk);
        #1;
        wait_drain();

        // Serial backpressure mid-word with a full buffer
        send_word(mk_word(16'h3000), 8'hFF, 1'b0);
        send_word(mk_word(16'h3100), 8'hFF, 1'b0);
        @(posedge clk);
        #1;
        bus.dn_serial_rdy = 1'b0;
        @(negedge clk);
        chk("full_rdy", 512'(bus.up_rdy), 512'(0));
        repeat (5) @(posedge clk);
        #1;
        bus.dn_serial_rdy = 1'b1;
        wait_drain();

        // Bypass word queued behind a serial word, then serial again
        send_word(mk_word(16'h4000), 8'hFF, 1'b0);
        send_word(fill_word(16'hABCD), 8'hFF, 1'b1);
        send_word(mk_word(16'h4100), 8'hFF, 1'b0);
        wait_drain();

        // Reset after three elements of a word
        base = ser_xfers;
        send_word(mk_word(16'h5000), 8'hFF, 1'b0);
        reached = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (ser_xfers >= base + 3) begin
                reached = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("rst_mid_wait", 512'(reached), 512'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("arst_ser_vld", 512'(bus.dn_serial_vld), 512'(0));
        chk("arst_ser_dat", 512'(bus.dn_serial_dat), 512'(0));
        chk("arst_last", 512'(bus.dn_serial_last), 512'(0));
        chk("arst_up_rdy", 512'(bus.up_rdy), 512'(0));
        model_reset();
        bus.length = 16'd12;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Frame of 12 ends mid-word
        send_word(mk_word(16'h6000), 8'hFF, 1'b0);
        send_word(mk_word(16'h6100), 8'hFF, 1'b0);
        send_word(mk_word(16'h6200), 8'hFF, 1'b0);
        wait_drain();

        // 32 words back-to-back, frame length 128
        @(negedge clk) rst_n = 1'b0;
        model_reset();
        bus.length = 16'd128;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        seen_rdy_low = 1'b0;
        lasts0 = n_last;
        for (int w = 0; w < 32; w++)
            send_word(mk_word(16'(16'h0100 + w*256)), 8'hFF, 1'b0);
        wait_drain();
        chk("stream_rdy_drop", 512'(seen_rdy_low), 512'(1));
        chk("stream_lasts", 512'(n_last - lasts0), 512'(2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
